// File: rtl/axil_aw_arbiter.sv
// axil_aw_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share one AXI-Lite
// write-address channel. A winner is accepted (req_ready pulse) whenever the
// channel is free, and its address is registered onto AXI_AWADDR one cycle
// later, so back-to-back grants give one address per cycle.
//
// Optional feature: define AXIL_AW_TIMEOUT_EN to build a stall counter that
// raises a sticky timeout_err after MAX_WAIT consecutive stalled cycles.
// Without the macro timeout_err is tied low and arbitration is unchanged.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. Requesters see req_ready as a one-hot accept
// strobe that is only ever high together with their own req_valid. On the
// master side AXI_AWVALID, AXI_AWADDR and grant_id are registered, never
// depend combinationally on AXI_AWREADY, and hold stable while stalled.
//
// dbg_state exposes the FSM state (0 = IDLE, 1 = ISSUE) for checkers.

module axil_aw_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WAIT   = 5
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_ARESETN,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]         AXI_AWADDR,
  output logic                          AXI_AWVALID,
  input  logic                          AXI_AWREADY,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          timeout_err,
  output logic                          dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("axil_aw_arbiter: NUM_REQ must be in 2..8");
  end
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("axil_aw_arbiter: MAX_WAIT must be at least 1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        rr_next;
  logic                    any_req;
  logic [IDX_W-1:0]        win_idx;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic                    free;
  logic                    accept;

  // Channel can take a new address when nothing is outstanding, or when the
  // outstanding one is being handed over in this very cycle.
  assign free = (state_q == IDLE) || AXI_AWREADY;

  // Round-robin pick: lowest valid index at or above rr_ptr, otherwise wrap
  // around to the lowest valid index overall.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    // Wrap-around candidate: lowest valid index anywhere.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_req = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    // Preferred candidate: lowest valid index not below rr_ptr overrides.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IDX_W'(i) >= rr_ptr)) begin
        win_idx = IDX_W'(i);
      end
    end
  end

  // Address mux for the selected requester.
  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Pointer moves one past the winner, wrapping at NUM_REQ-1.
  assign rr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

  // Next-state and accept strobe; req_ready is held low while in reset.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    req_ready = '0;
    if (AXI_ARESETN && free && any_req) begin
      accept = 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (win_idx == IDX_W'(i));
    end
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (AXI_AWREADY && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus registered master-side address, grant and pointer.
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      state_q    <= IDLE;
      AXI_AWADDR <= '0;
      grant_id   <= '0;
      rr_ptr     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        AXI_AWADDR <= win_addr;
        grant_id   <= win_idx;
        rr_ptr     <= rr_next;
      end
    end
  end

  assign AXI_AWVALID = (state_q == ISSUE);
  assign dbg_state   = state_q;

`ifdef AXIL_AW_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_next;

  // Count consecutive stalled cycles, saturating at MAX_WAIT; any cycle
  // without a stall restarts the count.
  always_comb begin
    stall_next = '0;
    if (AXI_AWVALID && !AXI_AWREADY) begin
      stall_next = (stall_cnt == CNT_W'(MAX_WAIT)) ? stall_cnt : stall_cnt + CNT_W'(1);
    end
  end

  // Counter register and sticky flag, set on the edge the count hits MAX_WAIT.
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      stall_cnt <= stall_next;
      if (stall_next == CNT_W'(MAX_WAIT)) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/axil_aw_arbiter.md
AXIL_AW_ARBITER -- requirements
Module: axil_aw_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters sharing one AXI-Lite write-address channel (range 2..8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, width of AXI_AWADDR and each requester address.
REQ-003 The block SHALL have parameter MAX_WAIT, default 5, the number of stalled AWVALID cycles after which a timeout is flagged.
REQ-004 The block SHALL have port AXI_ACLK  input  1  the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port AXI_ARESETN  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port req_valid  input  NUM_REQ  per-requester address request.
REQ-007 The block SHALL have port req_addr  input  NUM_REQ*ADDR_WIDTH  per-requester address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 The block SHALL have port req_ready  output  NUM_REQ  one-hot accept strobe to requesters.
REQ-009 The block SHALL have port AXI_AWADDR  output  ADDR_WIDTH  master write address.
REQ-010 The block SHALL have port AXI_AWVALID  output  1  master address valid.
REQ-011 The block SHALL have port AXI_AWREADY  input  1  slave address ready.
REQ-012 The block SHALL have port grant_id  output  clog2(NUM_REQ)  index of the requester owning the current AXI_AWVALID.
REQ-013 The block SHALL have port timeout_err  output  1  sticky stall-timeout flag.

Function
REQ-014 The block SHALL use states IDLE (AXI_AWVALID=0) and ISSUE (AXI_AWVALID=1).
REQ-015 The arbiter SHALL be "free" in IDLE, or in ISSUE during a cycle with AXI_AWREADY=1.
REQ-016 When free and any req_valid is 1, the block SHALL pick a winner round-robin, searching upward from rr_ptr and wrapping from NUM_REQ-1 to 0.
REQ-017 The block SHALL drive req_ready[winner]=1 combinationally in that cycle; all other req_ready bits SHALL be 0.
REQ-018 At the next edge the block SHALL register AXI_AWADDR=req_addr[winner] and grant_id=winner, enter or stay in ISSUE, and set rr_ptr=(winner+1) mod NUM_REQ.
REQ-019 Latency SHALL be one cycle from acceptance (req_ready high) to AXI_AWVALID high.
REQ-020 In ISSUE with AXI_AWREADY=1 and no req_valid, the block SHALL return to IDLE, deasserting AXI_AWVALID next cycle.
REQ-021 In ISSUE with AXI_AWREADY=1 and a pending request, the block SHALL load the new winner with AXI_AWVALID held high, giving back-to-back throughput of one address per cycle.
REQ-022 In ISSUE with AXI_AWREADY=0, AXI_AWVALID, AXI_AWADDR and grant_id SHALL stay stable, and all req_ready bits SHALL be 0.
REQ-023 AXI_AWVALID SHALL never depend combinationally on AXI_AWREADY.
REQ-024 A requester that drops req_valid before acceptance SHALL simply lose its turn; rr_ptr SHALL not change without a grant.

Reset
REQ-025 While AXI_ARESETN=0 at a clock edge, the block SHALL go to IDLE and clear AXI_AWVALID, AXI_AWADDR, grant_id, rr_ptr, the stall counter and timeout_err to 0; req_ready SHALL be 0 during reset.
REQ-026 AXI_AWVALID SHALL be 0 in the first cycle after AXI_ARESETN rises.
REQ-027 Reset asserted mid-ISSUE SHALL discard the outstanding address with no re-acceptance; the requester is not re-acked.

Configuration
REQ-028 With AXIL_AW_TIMEOUT_EN defined, a stall counter SHALL count consecutive cycles with AXI_AWVALID=1 and AXI_AWREADY=0, saturating at MAX_WAIT.
REQ-029 The stall counter SHALL clear on any cycle with AXI_AWREADY=1 or AXI_AWVALID=0.
REQ-030 timeout_err SHALL go high the cycle after the counter reaches MAX_WAIT and stay high until reset.
REQ-031 Without AXIL_AW_TIMEOUT_EN, no counter SHALL be built and timeout_err SHALL be tied 0; arbitration SHALL be identical in both builds.

Verification
REQ-032 Reset release with req_valid=4'b0001, addr0=8'h10, AXI_AWREADY=1 -> req_ready[0] in cycle 1; AWVALID=1, AWADDR=8'h10, grant_id=0 in cycle 2; AWVALID=0 in cycle 3.
REQ-033 All four requesters valid continuously (addrs 8'hA0..8'hA3), AXI_AWREADY=1 -> AWADDR sequence A0,A1,A2,A3,A0 on consecutive cycles with AWVALID held high.
REQ-034 Grant req2 (8'h22), AXI_AWREADY=0 for 3 cycles while req_addr2 changes to 8'h99 -> AWADDR stays 8'h22, AWVALID stays 1, req_ready=0 until the handshake.
REQ-035 Build with AXIL_AW_TIMEOUT_EN, AXI_AWREADY=0 for 5 AWVALID cycles -> timeout_err=1 from the 6th cycle and stays 1 after AXI_AWREADY=1; without the macro -> timeout_err stays 0.
REQ-036 AXI_ARESETN=0 for one edge during ISSUE -> AWVALID=0, grant_id=0, rr_ptr=0 next cycle; with req_valid=4'b1010 the next grant goes to req1.
